// File: rtl/ga_pkg.sv
// Shared constants for the gate-array interrupt generator.
package ga_pkg;

    localparam int unsigned GA_LINE_CNT_W      = 6;
    localparam int unsigned GA_IRQ_LINE        = 52;
    localparam int unsigned GA_VSYNC_HS_DELAY  = 2;
    localparam int unsigned GA_MON_VSYNC_LINES = 4;
    localparam int unsigned GA_IRQ_HALF        = 32;
    localparam int unsigned GA_MON_CNT_W       = 3;

endpackage

// File: rtl/ga_edge_detect.sv
// One-bit registered edge detector; RISE selects rising or falling edge.
module ga_edge_detect #(
    parameter bit RISE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_c
);

    logic q;

    always_ff @(posedge clk) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

    assign edge_c = RISE ? (~q & d) : (q & ~d);

endmodule

// File: rtl/irq_generator.sv
// Z80 maskable interrupt generator: line counter on HSYNC, VSYNC resync, ack and IRQ_RESET clear.
// Optional MON_VSYNC pulse output when IRQ_MON_VSYNC_EN is defined.
module irq_generator
    import ga_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = GA_LINE_CNT_W,
    parameter int unsigned IRQ_LINE       = GA_IRQ_LINE,
    parameter int unsigned VSYNC_HS_DELAY = GA_VSYNC_HS_DELAY
) (
    input  logic                 CLK_n,
    input  logic                 RESET_n,
    input  logic                 HSYNC,
    input  logic                 VSYNC,
    input  logic                 IRQ_RESET,
    input  logic                 M1_n,
    input  logic                 IORQ_n,
`ifdef IRQ_MON_VSYNC_EN
    output logic                 MON_VSYNC,
`endif
    output logic                 INT_n,
    output logic [CNT_WIDTH-1:0] LINE_CNT
);

    localparam int unsigned VS_W = $clog2(VSYNC_HS_DELAY + 1);
    localparam int unsigned CW1  = CNT_WIDTH + 1;

    logic hs_fall_c;
    logic vs_rise_c;
    logic ack_start_c;
    logic ack_lvl_c;
    logic resync_c;
    logic fire_c;

    logic [CW1-1:0]       cnt_inc_c;
    logic [CNT_WIDTH-1:0] line_nxt_c;
    logic                 int_nxt_c;
    logic                 armed_nxt_c;
    logic [VS_W-1:0]      vs_cnt_nxt_c;

    logic                 vs_armed;
    logic [VS_W-1:0]      vs_hs_cnt;

    assign ack_lvl_c = ~M1_n & ~IORQ_n;

    ga_edge_detect #(.RISE(1'b0)) u_hs_edge (
        .clk(CLK_n), .rst_n(RESET_n), .d(HSYNC), .edge_c(hs_fall_c)
    );

    ga_edge_detect #(.RISE(1'b1)) u_vs_edge (
        .clk(CLK_n), .rst_n(RESET_n), .d(VSYNC), .edge_c(vs_rise_c)
    );

    ga_edge_detect #(.RISE(1'b1)) u_ack_edge (
        .clk(CLK_n), .rst_n(RESET_n), .d(ack_lvl_c), .edge_c(ack_start_c)
    );

    // Resync completes on the armed HSYNC edge that reaches the delay count.
    assign resync_c  = vs_armed & hs_fall_c & ~vs_rise_c & ~IRQ_RESET &
                       (vs_hs_cnt == VS_W'(VSYNC_HS_DELAY - 1));
    assign cnt_inc_c = CW1'(LINE_CNT) + CW1'(1);

    // Next-state for counter, interrupt and VSYNC tracking, applied in priority order.
    always_comb begin
        line_nxt_c   = LINE_CNT;
        int_nxt_c    = INT_n;
        armed_nxt_c  = vs_armed;
        vs_cnt_nxt_c = vs_hs_cnt;
        fire_c       = 1'b0;

        if (vs_rise_c) begin
            armed_nxt_c  = 1'b1;
            vs_cnt_nxt_c = '0;
        end else if (vs_armed && hs_fall_c && !IRQ_RESET) begin
            vs_cnt_nxt_c = VS_W'(vs_hs_cnt + 1'b1);
            if (resync_c) armed_nxt_c = 1'b0;
        end

        if (IRQ_RESET) begin
            line_nxt_c = '0;
            int_nxt_c  = 1'b1;
        end else begin
            if (hs_fall_c) begin
                if (resync_c) begin
                    line_nxt_c = '0;
                    if (cnt_inc_c >= CW1'(GA_IRQ_HALF)) begin
                        int_nxt_c = 1'b0;
                        fire_c    = 1'b1;
                    end
                end else if (LINE_CNT == CNT_WIDTH'(IRQ_LINE - 1)) begin
                    line_nxt_c = '0;
                    int_nxt_c  = 1'b0;
                    fire_c     = 1'b1;
                end else begin
                    line_nxt_c = cnt_inc_c[CNT_WIDTH-1:0];
                end
            end
            // A firing edge in the same cycle wins over the acknowledge.
            if (ack_start_c && !fire_c) begin
                int_nxt_c  = 1'b1;
                line_nxt_c = line_nxt_c & ~CNT_WIDTH'(GA_IRQ_HALF);
            end
        end
    end

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            LINE_CNT  <= '0;
            INT_n     <= 1'b1;
            vs_armed  <= 1'b0;
            vs_hs_cnt <= '0;
        end else begin
            LINE_CNT  <= line_nxt_c;
            INT_n     <= int_nxt_c;
            vs_armed  <= armed_nxt_c;
            vs_hs_cnt <= vs_cnt_nxt_c;
        end
    end

`ifdef IRQ_MON_VSYNC_EN
    logic [GA_MON_CNT_W-1:0] mon_cnt;
    logic [GA_MON_CNT_W-1:0] mon_cnt_nxt_c;
    logic                    mon_nxt_c;

    // Monitor pulse: starts on resync, lasts a fixed number of lines, cut by VSYNC low.
    always_comb begin
        mon_nxt_c     = MON_VSYNC;
        mon_cnt_nxt_c = mon_cnt;
        if (resync_c && !MON_VSYNC) begin
            mon_nxt_c     = 1'b1;
            mon_cnt_nxt_c = '0;
        end else if (MON_VSYNC) begin
            if (!VSYNC) begin
                mon_nxt_c = 1'b0;
            end else if (hs_fall_c) begin
                if (mon_cnt == GA_MON_CNT_W'(GA_MON_VSYNC_LINES - 1)) mon_nxt_c = 1'b0;
                else mon_cnt_nxt_c = GA_MON_CNT_W'(mon_cnt + 1'b1);
            end
        end
    end

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            MON_VSYNC <= 1'b0;
            mon_cnt   <= '0;
        end else begin
            MON_VSYNC <= mon_nxt_c;
            mon_cnt   <= mon_cnt_nxt_c;
        end
    end
`endif

endmodule

// File: tb/tb_irq_generator.sv
// Self-checking bench for irq_generator: directed scenarios plus randomized run against a reference model.
module tb_irq_generator;

    localparam int IRQ_LINE  = 52;
    localparam int VS_DELAY  = 2;
    localparam int MON_LINES = 4;
    localparam int HALF      = 32;

    logic       clk_n = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       irq_reset = 1'b0;
    logic       m1_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic       int_n;
    logic [5:0] line_cnt;
    logic       mon_vsync;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_line, m_vs_seen, m_mon_n;
    bit m_int, m_armed, m_mon, m_hs_prev, m_vs_prev, m_ack_prev;

    irq_generator dut (
        .CLK_n(clk_n), .RESET_n(rst_n), .HSYNC(hsync), .VSYNC(vsync),
        .IRQ_RESET(irq_reset), .M1_n(m1_n), .IORQ_n(iorq_n),
`ifdef IRQ_MON_VSYNC_EN
        .MON_VSYNC(mon_vsync),
`endif
        .INT_n(int_n), .LINE_CNT(line_cnt)
    );

`ifndef IRQ_MON_VSYNC_EN
    assign mon_vsync = 1'b0;
`endif

    always #5 clk_n = ~clk_n;

    // Advance one clock and apply the behavioural rules to the model using the sampled inputs.
    task automatic tick();
        bit hf, vr, ackl, as, fire, resync;
        @(posedge clk_n);
        if (!rst_n) begin
            m_line = 0; m_int = 1; m_armed = 0; m_vs_seen = 0;
            m_mon = 0; m_mon_n = 0;
            m_hs_prev = 0; m_vs_prev = 0; m_ack_prev = 0;
        end else begin
            hf     = m_hs_prev && !hsync;
            vr     = !m_vs_prev && vsync;
            ackl   = !m1_n && !iorq_n;
            as     = ackl && !m_ack_prev;
            fire   = 0;
            resync = 0;
            if (vr) begin
                m_armed = 1; m_vs_seen = 0;
            end else if (m_armed && hf && !irq_reset) begin
                m_vs_seen++;
                if (m_vs_seen == VS_DELAY) begin resync = 1; m_armed = 0; end
            end
            if (irq_reset) begin
                m_line = 0; m_int = 1;
            end else begin
                if (hf) begin
                    if (resync) begin
                        if (m_line + 1 >= HALF) begin m_int = 0; fire = 1; end
                        m_line = 0;
                    end else if (m_line + 1 == IRQ_LINE) begin
                        m_line = 0; m_int = 0; fire = 1;
                    end else begin
                        m_line = m_line + 1;
                    end
                end
                if (as && !fire) begin m_int = 1; m_line = m_line % HALF; end
            end
            if (resync && !m_mon) begin
                m_mon = 1; m_mon_n = 0;
            end else if (m_mon) begin
                if (!vsync) m_mon = 0;
                else if (hf) begin
                    m_mon_n++;
                    if (m_mon_n == MON_LINES) m_mon = 0;
                end
            end
            m_hs_prev = hsync; m_vs_prev = vsync; m_ack_prev = ackl;
        end
        #1;
    endtask

    task automatic hs_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            hsync = 1'b1; tick();
            hsync = 1'b0; tick();
        end
    endtask

    task automatic do_ack();
        m1_n = 1'b0; iorq_n = 1'b0; tick();
        m1_n = 1'b1; iorq_n = 1'b1; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick();
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd0 || mon_vsync !== 1'b0) begin
            $display("FAIL reset: int_n=%b line=%0d mon=%b, want 1/0/0", int_n, line_cnt, mon_vsync);
            bad++;
        end
        rst_n = 1'b1; tick();
    endtask

    task automatic test_count();
        hs_pulse(51);
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd51) begin
            $display("FAIL count51: int_n=%b line=%0d, want 1/51", int_n, line_cnt); bad++;
        end
        hsync = 1'b1; tick();
        hsync = 1'b0; tick();
        total++;
        if (int_n !== 1'b0 || line_cnt !== 6'd0) begin
            $display("FAIL count52: int_n=%b line=%0d, want 0/0", int_n, line_cnt); bad++;
        end
    endtask

    task automatic test_ack();
        hs_pulse(40);
        total++;
        if (int_n !== 1'b0 || line_cnt !== 6'd40) begin
            $display("FAIL ack_pre: int_n=%b line=%0d, want 0/40", int_n, line_cnt); bad++;
        end
        m1_n = 1'b0; iorq_n = 1'b0;
        tick(); tick(); tick();
        m1_n = 1'b1; iorq_n = 1'b1; tick();
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd8) begin
            $display("FAIL ack: int_n=%b line=%0d, want 1/8", int_n, line_cnt); bad++;
        end
        hs_pulse(1);
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd9) begin
            $display("FAIL ack_once: int_n=%b line=%0d, want 1/9", int_n, line_cnt); bad++;
        end
    endtask

    task automatic test_irq_reset();
        hs_pulse(11);
        total++;
        if (line_cnt !== 6'd20) begin
            $display("FAIL irqr_pre: line=%0d, want 20", line_cnt); bad++;
        end
        irq_reset = 1'b1; tick(); irq_reset = 1'b0;
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd0) begin
            $display("FAIL irq_reset: int_n=%b line=%0d, want 1/0", int_n, line_cnt); bad++;
        end
        hs_pulse(52);
        total++;
        if (int_n !== 1'b0 || line_cnt !== 6'd0) begin
            $display("FAIL irqr_next: int_n=%b line=%0d, want 0/0", int_n, line_cnt); bad++;
        end
    endtask

    task automatic test_vsync();
        do_ack();
        hs_pulse(35);
        vsync = 1'b1; tick();
        hs_pulse(VS_DELAY);
        total++;
        if (int_n !== 1'b0 || line_cnt !== 6'd0) begin
            $display("FAIL vs_late: int_n=%b line=%0d, want 0/0", int_n, line_cnt); bad++;
        end
        vsync = 1'b0; tick();
        do_ack();
        hs_pulse(10);
        vsync = 1'b1; tick();
        hs_pulse(VS_DELAY);
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd0) begin
            $display("FAIL vs_early: int_n=%b line=%0d, want 1/0", int_n, line_cnt); bad++;
        end
        vsync = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        hs_pulse(51);
        hsync = 1'b1; tick();
        hsync = 1'b0; m1_n = 1'b0; iorq_n = 1'b0; tick();
        total++;
        if (int_n !== 1'b0 || line_cnt !== 6'd0) begin
            $display("FAIL hs_ack: int_n=%b line=%0d, want 0/0", int_n, line_cnt); bad++;
        end
        m1_n = 1'b1; iorq_n = 1'b1; tick();
        irq_reset = 1'b1; tick(); irq_reset = 1'b0;
        hs_pulse(51);
        hsync = 1'b1; tick();
        hsync = 1'b0; irq_reset = 1'b1; tick(); irq_reset = 1'b0;
        total++;
        if (int_n !== 1'b1 || line_cnt !== 6'd0) begin
            $display("FAIL hs_irqr: int_n=%b line=%0d, want 1/0", int_n, line_cnt); bad++;
        end
    endtask

`ifdef IRQ_MON_VSYNC_EN
    task automatic test_mon_vsync();
        bit want;
        vsync = 1'b1; tick();
        for (int i = 1; i <= 8; i++) begin
            hs_pulse(1);
            want = (i >= 2 && i <= 5);
            total++;
            if (mon_vsync !== want) begin
                $display("FAIL mon_line%0d: mon=%b, want %b", i, mon_vsync, want); bad++;
            end
        end
        vsync = 1'b0; tick();
        vsync = 1'b1; tick();
        hs_pulse(3);
        total++;
        if (mon_vsync !== 1'b1) begin
            $display("FAIL mon_cut_pre: mon=%b, want 1", mon_vsync); bad++;
        end
        vsync = 1'b0; tick();
        total++;
        if (mon_vsync !== 1'b0) begin
            $display("FAIL mon_cut: mon=%b, want 0", mon_vsync); bad++;
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2) == 0) hsync = ~hsync;
            if ($urandom_range(59) == 0) vsync = ~vsync;
            if ($urandom_range(9) == 0) begin
                m1_n = ~m1_n; iorq_n = m1_n;
            end
            irq_reset = ($urandom_range(149) == 0);
            tick();
            total++;
            if (int_n !== m_int || line_cnt !== 6'(m_line)) begin
                $display("FAIL rand%0d: int_n=%b line=%0d, want %b/%0d", i, int_n, line_cnt, m_int, m_line);
                bad++;
            end
`ifdef IRQ_MON_VSYNC_EN
            total++;
            if (mon_vsync !== m_mon) begin
                $display("FAIL rand_mon%0d: mon=%b, want %b", i, mon_vsync, m_mon); bad++;
            end
`endif
        end
        irq_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_ack();
        test_irq_reset();
        test_vsync();
        test_back_to_back();
`ifdef IRQ_MON_VSYNC_EN
        test_mon_vsync();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
